_rf_wr_arb: RTL

Register-file write-port arbiter for the single-issue core. It shares the one register-file write port between the ALU write-back source and the load-unit write-back source, and registers the chosen write. It also expands the destination index into the 32-bit one-hot write-enable bus through the existing 5-to-32 decoder. Fixed priority favours the ALU, and a starvation counter bounds how long a pending load can wait.

---
 rtl/_rf_wr_arb_pkg.sv | 26 ++
 rtl/_rf_wr_arb_dec32.sv | 15 +
 rtl/_rf_wr_arb.sv | 109 ++++++++++
 3 files changed

// File: rtl/_rf_wr_arb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package _rf_wr_arb_pkg;

  localparam int unsigned RF_AW = 5;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 3;

  // Which write-back source owns the port this cycle.
  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LD  = 1'b1
  } src_e;

  // Arbitration priority mode.
  typedef enum logic {
    NORMAL     = 1'b0,
    LOAD_FIRST = 1'b1
  } state_e;

  // Write payload presented to the register file.
  typedef struct packed {
    logic [RF_AW-1:0] rd;
    logic [XLEN-1:0]  data;
  } wr_t;

endpackage

// File: rtl/_rf_wr_arb_dec32.sv
// 5-to-32 one-hot decoder used for register-file write-enable expansion.
module _dec32
  import _rf_wr_arb_pkg::*;
(
  input  logic [RF_AW-1:0] idx,
  output logic [XLEN-1:0]  onehot
);

  // Set exactly the bit selected by idx.
  always_comb begin
    onehot      = '0;
    onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/_rf_wr_arb.sv
// Register-file write-port arbiter: ALU-priority with bounded load starvation,
// one registered write per cycle, one-hot write-enable expansion.
module _rf_wr_arb
  import _rf_wr_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIM = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alu_valid,
  input  logic [RF_AW-1:0] alu_rd,
  input  logic [XLEN-1:0]  alu_data,
  output logic             alu_ready,
  input  logic             ld_valid,
  input  logic [RF_AW-1:0] ld_rd,
  input  logic [XLEN-1:0]  ld_data,
  output logic             ld_ready,
  output logic [XLEN-1:0]  rf_we,
  output logic [RF_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  output logic             rf_wvalid
);

  localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIM);

  state_e           state;
  state_e           state_nxt;
  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] cnt_nxt;
  src_e             src;
  logic             grant;
  wr_t              win;
  logic [XLEN-1:0]  dec_oh;

  // Grant selection, starvation counter and next-state logic.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = starve_cnt;
    alu_ready = 1'b0;
    ld_ready  = 1'b0;
    src       = SRC_ALU;

    case (state)
      NORMAL: begin
        if (alu_valid)     alu_ready = 1'b1;
        else if (ld_valid) ld_ready  = 1'b1;
      end
      LOAD_FIRST: begin
        if (ld_valid)       ld_ready  = 1'b1;
        else if (alu_valid) alu_ready = 1'b1;
      end
      default: ;
    endcase

    if (ld_ready) src = SRC_LD;
    grant = alu_ready | ld_ready;

    // A load that is absent or accepted owes no wait; otherwise count up to the limit.
    if (!ld_valid || ld_ready)  cnt_nxt = '0;
    else if (starve_cnt != LIM) cnt_nxt = starve_cnt + CNT_W'(1);

    case (state)
      NORMAL:     if (cnt_nxt == LIM) state_nxt = LOAD_FIRST;
      LOAD_FIRST: if (!ld_valid || ld_ready) state_nxt = NORMAL;
      default:    state_nxt = NORMAL;
    endcase

    win.rd   = (src == SRC_LD) ? ld_rd   : alu_rd;
    win.data = (src == SRC_LD) ? ld_data : alu_data;
  end

  // FSM state and starvation counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= NORMAL;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= cnt_nxt;
    end
  end

  // Registered write; address/data hold when nothing is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_wvalid <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
    end else begin
      rf_wvalid <= grant;
      if (grant) begin
        rf_waddr <= win.rd;
        rf_wdata <= win.data;
      end
    end
  end

  _dec32 u_dec32 (
    .idx    (rf_waddr),
    .onehot (dec_oh)
  );

  // Write enables come from registers only; x0 is never enabled.
  always_comb begin
    rf_we = '0;
    if (rf_wvalid) rf_we = dec_oh & 32'hFFFF_FFFE;
  end

endmodule
